add_serial_arb: RTL
===================

ADD_SERIAL_ARB -- requirements
Module: add_serial_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, reset (asynchronous, active-low).
REQ-004 The block SHALL have port req, input, 4, per-requester add request (level).
REQ-005 The block SHALL have port a_in, input, 4*WIDTH, operand A; requester i uses slice [WIDTH*i +: WIDTH].
REQ-006 The block SHALL have port b_in, input, 4*WIDTH, operand B, sliced as a_in.
REQ-007 The block SHALL have port gnt, output, 4, one-hot grant, high while requester i owns the adder.
REQ-008 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-009 The block SHALL have port rsp_valid, output, 1, high for exactly the one DONE cycle.
REQ-010 The block SHALL have ports rsp_id (output, 2, granted index), rsp_sum (output, WIDTH, result) and rsp_cout (output, 1, carry-out), all valid while rsp_valid is high.

Function
REQ-011 The block SHALL implement FSM IDLE -> ADD -> DONE -> IDLE, containing one internal bit-serial adder shared by four requesters.
REQ-012 In IDLE with req!=0, the block SHALL, at the clock edge, pick the winner round-robin starting at rr_ptr, set gnt one-hot, load a_reg/b_reg from the winner's slices, clear count, carry and the sum shift register, and go to ADD.
REQ-013 In IDLE with req==0, all registers SHALL hold.
REQ-014 In ADD, each cycle SHALL compute sum = a_reg[0]^b_reg[0]^carry and carry_next = majority(a_reg[0],b_reg[0],carry), shift a_reg/b_reg right by 1, shift sum into the sum register MSB (LSB-first), and increment count.
REQ-015 ADD SHALL last exactly WIDTH cycles; at count==WIDTH-1 the next state SHALL be DONE.
REQ-016 In DONE, rsp_valid SHALL be 1, rsp_id = winner, rsp_sum = the assembled sum, rsp_cout = final carry, and at the edge rr_ptr SHALL become (winner+1) mod 4, gnt SHALL clear and state SHALL return to IDLE.
REQ-017 Latency SHALL be: request seen in IDLE at cycle 0, rsp_valid at cycle WIDTH+1; one operation per WIDTH+2 cycles maximum.
REQ-018 Operands SHALL be sampled only at the grant edge; later changes to a_in/b_in SHALL NOT affect the result.
REQ-019 Deassertion of the granted req mid-operation SHALL NOT abort; the response SHALL still be issued.
REQ-020 Requests arriving while busy SHALL wait; a request held through DONE SHALL compete normally in the next IDLE cycle.
REQ-021 rr_ptr wrap-around SHALL be 3 -> 0; with req=4'b1111 held, grant order SHALL be 0,1,2,3,0.
REQ-022 rsp_sum/rsp_cout SHALL hold their last value outside DONE; only rsp_valid qualifies them.

Reset
REQ-023 While rst is low, the block SHALL immediately force state=IDLE, gnt=0, busy=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rr_ptr=0, count=0, carry=0, a_reg=b_reg=0.
REQ-024 Reset asserted mid-ADD or in DONE SHALL discard the operation with no rsp_valid pulse; the first grant after release SHALL start from requester 0.

Configuration
REQ-025 With macro ADD_SERIAL_ARB_SAT_EN defined, DONE SHALL present rsp_sum = all-ones when the final carry is 1 (saturating add); rsp_cout still reports the carry.
REQ-026 Without ADD_SERIAL_ARB_SAT_EN, rsp_sum SHALL be the modulo-2^WIDTH sum.

Verification
REQ-027 WIDTH=8, req=0001, a0=0x35, b0=0x4A at cycle 0 -> gnt=0001 cycles 1-9, rsp_valid at cycle 9 only, rsp_id=0, rsp_sum=0x7F, rsp_cout=0.
REQ-028 req=0100, a2=0xFF, b2=0x01 -> rsp_id=2, rsp_cout=1, rsp_sum=0x00 (0xFF with ADD_SERIAL_ARB_SAT_EN).
REQ-029 req=1111 held, a_i=i, b_i=0x10 -> responses at cycles 9,19,29,39,49 with ids 0,1,2,3,0 and sums 0x10,0x11,0x12,0x13,0x10.
REQ-030 req=0010, a1=0x0F, b1=0x0F; at cycle 3 drop req and change a1 to 0xAA -> rsp at cycle 9, rsp_id=1, rsp_sum=0x1E.
REQ-031 req=1000 at cycle 0, rst low at cycle 4 for 2 cycles -> all outputs 0 immediately, no rsp_valid; after release req=1001 -> first grant to requester 0.

Source files
------------

// File: rtl/add_serial_arb.sv
// Purpose: four requesters share one bit-serial adder through a round-robin arbiter.
// Latency: request seen in IDLE at cycle 0 -> rsp_valid at cycle WIDTH+1; one op per WIDTH+2 cycles.
// Backpressure: none on the response side; losing/late requests simply wait while busy.
// Optional: define ADD_SERIAL_ARB_SAT_EN to saturate rsp_sum to all-ones on carry-out.
module add_serial_arb #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   a_in,
  input  logic [4*WIDTH-1:0]   b_in,
  output logic [3:0]           gnt,
  output logic                 busy,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_id,
  output logic [WIDTH-1:0]     rsp_sum,
  output logic                 rsp_cout
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       rr_ptr;
  logic [1:0]       win;
  logic [CW-1:0]    count;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_cout_q;

  logic             pick_vld;
  logic [1:0]       pick_id;
  logic [1:0]       cand;
  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] sum_full;
  logic [WIDTH-1:0] final_sum;

  // Round-robin pick: scan from rr_ptr downward in priority so the nearest requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = rr_ptr;
    cand     = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr + 2'(k);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  // One full-adder slice per cycle; the sum bit enters at the MSB so LSB ends at bit 0.
  always_comb begin
    sum_bit   = a_reg[0] ^ b_reg[0] ^ carry;
    carry_nxt = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);
    sum_full  = {sum_bit, sum_sr[WIDTH-1:1]};
`ifdef ADD_SERIAL_ARB_SAT_EN
    final_sum = carry_nxt ? {WIDTH{1'b1}} : sum_full;
`else
    final_sum = sum_full;
`endif
  end

  // Arbitration FSM plus serial datapath; response fields latch on the last ADD edge and hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      gnt        <= 4'b0;
      rr_ptr     <= 2'd0;
      win        <= 2'd0;
      count      <= '0;
      carry      <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      sum_sr     <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            gnt    <= 4'b0001 << pick_id;
            win    <= pick_id;
            a_reg  <= a_in[WIDTH*pick_id +: WIDTH];
            b_reg  <= b_in[WIDTH*pick_id +: WIDTH];
            count  <= '0;
            carry  <= 1'b0;
            sum_sr <= '0;
            state  <= S_ADD;
          end
        end
        S_ADD: begin
          a_reg  <= a_reg >> 1;
          b_reg  <= b_reg >> 1;
          carry  <= carry_nxt;
          sum_sr <= sum_full;
          count  <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            rsp_sum_q  <= final_sum;
            rsp_cout_q <= carry_nxt;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          rr_ptr <= win + 2'd1;
          gnt    <= 4'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign rsp_id    = win;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;

endmodule
